g2_chain_walker: RTL and testbench

- Control stage directly upstream of the per-table G2 search memory.
- Accepts a lookup request (104-bit 5-tuple plus head index of a G2 chain) and drives the table's search_index and tupleData ports.
- Follows next_index links hop by hop and keeps the best (lowest) matching ruleID; returns one result per request.
- Also owns the table write port and serialises rule-update writes against lookups.

---
 rtl/g2_pkg.sv | 37 +++
 rtl/g2_walk_stats.sv | 44 ++++
 rtl/g2_chain_walker.sv | 201 ++++++++++++++++++++
 tb/tb_g2_chain_walker.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/g2_pkg.sv
// -----------------------------------------------------------------------------
// g2_pkg : shared definitions for the G2 chain walker.
//   - default widths for table index / ruleID / next_index, tuple and entry
//   - bit offsets of the 5-tuple fields and of the table entry fields
//   - walker FSM state encoding
// Optional feature macro used by the walker: G2_WALK_STATS_EN
// -----------------------------------------------------------------------------
package g2_pkg;

   localparam int IDX_W    = 11;
   localparam int TUPLE_W  = 104;
   localparam int ENTRY_W  = 171;
   localparam int NULL_IDX = 0;
   localparam int MAX_HOPS = 19;

   // 5-tuple field LSB offsets
   localparam int TUP_SRC_IP_LSB   = 0;
   localparam int TUP_DST_IP_LSB   = 32;
   localparam int TUP_SRC_PORT_LSB = 64;
   localparam int TUP_DST_PORT_LSB = 80;
   localparam int TUP_PROTO_LSB    = 96;

   // table entry field offsets
   localparam int ENT_NEXT_MSB   = 170;
   localparam int ENT_NEXT_LSB   = 160;
   localparam int ENT_RULE_MSB   = 159;
   localparam int ENT_RULE_LSB   = 149;
   localparam int ENT_WILD_PROTO = 148;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      EVAL  = 2'd2,
      RESP  = 2'd3
   } walk_state_e;

endpackage

// File: rtl/g2_walk_stats.sv
// -----------------------------------------------------------------------------
// g2_walk_stats : saturating walk statistics (built only with G2_WALK_STATS_EN).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   lookup          a lookup request was accepted this cycle
//   done            a walk completes (response is being loaded) this cycle
//   done_hit        hit flag of the completing walk
//   done_hops       hop count of the completing walk
//   stat_lookups    accepted requests
//   stat_hits       responses with hit
//   stat_max_hops   largest hop count of any completed walk
// -----------------------------------------------------------------------------
module g2_walk_stats #(
   parameter int IDX_W = g2_pkg::IDX_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             lookup,
   input  logic             done,
   input  logic             done_hit,
   input  logic [IDX_W-1:0] done_hops,
   output logic [31:0]      stat_lookups,
   output logic [31:0]      stat_hits,
   output logic [IDX_W-1:0] stat_max_hops
);
   import g2_pkg::*;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_lookups  <= '0;
         stat_hits     <= '0;
         stat_max_hops <= '0;
      end else begin
         if (lookup && (stat_lookups != '1))
            stat_lookups <= stat_lookups + 32'd1;
         if (done && done_hit && (stat_hits != '1))
            stat_hits <= stat_hits + 32'd1;
         // a max register cannot pass all-ones, so it saturates by construction
         if (done && (done_hops > stat_max_hops))
            stat_max_hops <= done_hops;
      end
   end

endmodule

// File: rtl/g2_chain_walker.sv
// -----------------------------------------------------------------------------
// g2_chain_walker : control stage in front of one G2 search table.
// Walks a linked chain of table entries starting at req_head, keeps the lowest
// matching ruleID and returns one response per request. Also owns the table
// write port; table writes take priority but are only issued while IDLE.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_*                       lookup request (tuple + chain head)
//   upd_*                       table write request
//   tbl_search_index/tuple/we/din   registered drive of the table ports
//   tbl_match/ruleID/next_index     table result, one cycle after the index
//   rsp_*                       lookup response (held until rsp_ready)
//   stat_*                      walk statistics (only with G2_WALK_STATS_EN)
// Optional feature macro: G2_WALK_STATS_EN
// -----------------------------------------------------------------------------
module g2_chain_walker #(
   parameter int IDX_W    = g2_pkg::IDX_W,
   parameter int TUPLE_W  = g2_pkg::TUPLE_W,
   parameter int ENTRY_W  = g2_pkg::ENTRY_W,
   parameter int NULL_IDX = g2_pkg::NULL_IDX,
   parameter int MAX_HOPS = g2_pkg::MAX_HOPS
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [TUPLE_W-1:0] req_tuple,
   input  logic [IDX_W-1:0]   req_head,
   input  logic               upd_valid,
   output logic               upd_ready,
   input  logic [IDX_W-1:0]   upd_addr,
   input  logic [ENTRY_W-1:0] upd_data,
   output logic [IDX_W-1:0]   tbl_search_index,
   output logic [TUPLE_W-1:0] tbl_tuple,
   output logic               tbl_we,
   output logic [ENTRY_W-1:0] tbl_din,
   input  logic               tbl_match,
   input  logic [IDX_W-1:0]   tbl_ruleID,
   input  logic [IDX_W-1:0]   tbl_next_index,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_hit,
   output logic [IDX_W-1:0]   rsp_ruleID,
`ifdef G2_WALK_STATS_EN
   output logic [31:0]        stat_lookups,
   output logic [31:0]        stat_hits,
   output logic [IDX_W-1:0]   stat_max_hops,
`endif
   output logic               rsp_overflow
);
   import g2_pkg::*;

   localparam logic [IDX_W-1:0] NULL_I  = IDX_W'(NULL_IDX);
   localparam logic [IDX_W-1:0] HOP_LIM = IDX_W'(MAX_HOPS);

   walk_state_e        state_q, state_d;
   logic [IDX_W-1:0]   hops_q, hops_d;
   logic [IDX_W-1:0]   best_q, best_d;
   logic               hit_q, hit_d;

   logic               req_ready_d, upd_ready_d, tbl_we_d;
   logic [IDX_W-1:0]   idx_d;
   logic [TUPLE_W-1:0] tuple_d;
   logic [ENTRY_W-1:0] din_d;
   logic               rsp_valid_d, rsp_hit_d, rsp_ovf_d;
   logic [IDX_W-1:0]   rsp_rule_d;

   // result of folding the current probe into the running best
   logic               better;
   logic [IDX_W-1:0]   best_upd;
   logic               hit_upd;
   logic [IDX_W-1:0]   hops_inc;

   assign better   = tbl_match && (tbl_ruleID < best_q);
   assign best_upd = better ? tbl_ruleID : best_q;
   assign hit_upd  = hit_q | better;
   assign hops_inc = hops_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      hops_d      = hops_q;
      best_d      = best_q;
      hit_d       = hit_q;
      idx_d       = tbl_search_index;
      tuple_d     = tbl_tuple;
      din_d       = tbl_din;
      tbl_we_d    = 1'b0;
      upd_ready_d = 1'b0;
      rsp_valid_d = rsp_valid;
      rsp_hit_d   = rsp_hit;
      rsp_rule_d  = rsp_ruleID;
      rsp_ovf_d   = rsp_overflow;

      case (state_q)
         IDLE: begin
            // upd_ready high means the write already went out this cycle;
            // the requester drops upd_valid on that edge, so skip a rewrite.
            if (upd_valid && !upd_ready) begin
               tbl_we_d    = 1'b1;
               upd_ready_d = 1'b1;
               idx_d       = upd_addr;
               din_d       = upd_data;
            end else if (req_valid && req_ready && !upd_valid) begin
               tuple_d   = req_tuple;
               idx_d     = req_head;
               hops_d    = '0;
               best_d    = '1;
               hit_d     = 1'b0;
               rsp_ovf_d = 1'b0;
               if (req_head == NULL_I) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_hit_d   = 1'b0;
                  rsp_rule_d  = '0;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: state_d = EVAL;
         EVAL: begin
            best_d = best_upd;
            hit_d  = hit_upd;
            hops_d = hops_inc;
            if (tbl_next_index == NULL_I || hops_inc == HOP_LIM) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_hit_d   = hit_upd;
               rsp_rule_d  = hit_upd ? best_upd : '0;
               rsp_ovf_d   = (tbl_next_index != NULL_I);
            end else begin
               idx_d   = tbl_next_index;
               state_d = ISSUE;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // registered ready: open only in IDLE with no write pending
      req_ready_d = (state_d == IDLE) && !upd_valid;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         hops_q           <= '0;
         best_q           <= '0;
         hit_q            <= 1'b0;
         req_ready        <= 1'b0;
         upd_ready        <= 1'b0;
         tbl_we           <= 1'b0;
         tbl_search_index <= '0;
         tbl_tuple        <= '0;
         tbl_din          <= '0;
         rsp_valid        <= 1'b0;
         rsp_hit          <= 1'b0;
         rsp_ruleID       <= '0;
         rsp_overflow     <= 1'b0;
      end else begin
         state_q          <= state_d;
         hops_q           <= hops_d;
         best_q           <= best_d;
         hit_q            <= hit_d;
         req_ready        <= req_ready_d;
         upd_ready        <= upd_ready_d;
         tbl_we           <= tbl_we_d;
         tbl_search_index <= idx_d;
         tbl_tuple        <= tuple_d;
         tbl_din          <= din_d;
         rsp_valid        <= rsp_valid_d;
         rsp_hit          <= rsp_hit_d;
         rsp_ruleID       <= rsp_rule_d;
         rsp_overflow     <= rsp_ovf_d;
      end
   end

`ifdef G2_WALK_STATS_EN
   logic st_lookup, st_done;
   assign st_lookup = (state_q == IDLE) && (state_d != IDLE);
   assign st_done   = (state_q != RESP) && (state_d == RESP);

   g2_walk_stats #(.IDX_W(IDX_W)) u_stats (
      .clk           (clk),
      .rst_n         (rst_n),
      .lookup        (st_lookup),
      .done          (st_done),
      .done_hit      (rsp_hit_d),
      .done_hops     (hops_d),
      .stat_lookups  (stat_lookups),
      .stat_hits     (stat_hits),
      .stat_max_hops (stat_max_hops)
   );
`endif

endmodule

// File: tb/tb_g2_chain_walker.sv
// -----------------------------------------------------------------------------
// tb_g2_chain_walker : self-checking bench for g2_chain_walker.
// A stub search table (exact tuple match on entry bits [103:0]) is loaded
// through the walker's own write port; a shadow copy feeds the reference walk.
// -----------------------------------------------------------------------------
module tb_g2_chain_walker;
   localparam int MAX_HOPS = 19;

   logic         clk, rst_n;
   logic         req_valid, req_ready;
   logic [103:0] req_tuple;
   logic [10:0]  req_head;
   logic         upd_valid, upd_ready;
   logic [10:0]  upd_addr;
   logic [170:0] upd_data;
   logic [10:0]  tbl_search_index;
   logic [103:0] tbl_tuple;
   logic         tbl_we;
   logic [170:0] tbl_din;
   logic         tbl_match;
   logic [10:0]  tbl_ruleID, tbl_next_index;
   logic         rsp_valid, rsp_ready, rsp_hit, rsp_overflow;
   logic [10:0]  rsp_ruleID;
`ifdef G2_WALK_STATS_EN
   logic [31:0]  stat_lookups, stat_hits;
   logic [10:0]  stat_max_hops;
`endif

   g2_chain_walker dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_tuple(req_tuple), .req_head(req_head),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr), .upd_data(upd_data),
      .tbl_search_index(tbl_search_index), .tbl_tuple(tbl_tuple), .tbl_we(tbl_we), .tbl_din(tbl_din),
      .tbl_match(tbl_match), .tbl_ruleID(tbl_ruleID), .tbl_next_index(tbl_next_index),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_ruleID(rsp_ruleID),
`ifdef G2_WALK_STATS_EN
      .stat_lookups(stat_lookups), .stat_hits(stat_hits), .stat_max_hops(stat_max_hops),
`endif
      .rsp_overflow(rsp_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stub table: registered read, one cycle after the index
   logic [170:0] mem [2048];
   always @(posedge clk) begin
      if (tbl_we) mem[tbl_search_index] <= tbl_din;
      tbl_match      <= (mem[tbl_search_index][103:0] == tbl_tuple);
      tbl_ruleID     <= mem[tbl_search_index][159:149];
      tbl_next_index <= mem[tbl_search_index][170:160];
   end

   // shadow of table contents for the reference walk
   logic        sm [2048];
   logic [10:0] sr [2048];
   logic [10:0] sn [2048];

   logic [103:0] tup_a;
   logic         lk_done;
   int n_chk = 0, n_pass = 0;

   typedef struct {
      logic [10:0] head;
      logic        hit;
      logic [10:0] rid;
      logic        ovf;
      int          lat;
      int          stall;
   } vec_t;
   vec_t vt [6];

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic chk_reset(input string t);
      chk({t, "_ctl"}, {122'd0, req_ready, upd_ready, tbl_we, rsp_valid, rsp_hit, rsp_overflow}, 128'd0);
      chk({t, "_rule"}, {117'd0, rsp_ruleID}, 128'd0);
      chk({t, "_idx"}, {117'd0, tbl_search_index}, 128'd0);
      chk({t, "_tuple"}, {24'd0, tbl_tuple}, 128'd0);
      chk({t, "_din_nz"}, {127'd0, |tbl_din}, 128'd0);
   endtask

   // reference: follow links, keep the strictly lowest matching ruleID
   function automatic void ref_walk(input logic [10:0] head, output logic h,
                                    output logic [10:0] r, output logic o, output int lat);
      logic [10:0] idx, best;
      int probes;
      h = 1'b0; o = 1'b0; best = '1; probes = 0; idx = head;
      if (head == 11'd0) begin
         r = '0; lat = 1;
         return;
      end
      while (1) begin
         probes++;
         if (sm[idx] && sr[idx] < best) begin best = sr[idx]; h = 1'b1; end
         if (sn[idx] == 11'd0) break;
         if (probes == MAX_HOPS) begin o = 1'b1; break; end
         idx = sn[idx];
      end
      r = h ? best : 11'd0;
      lat = 2 * probes + 1;
   endfunction

   function automatic logic [170:0] mk_entry(input logic m, input logic [10:0] rid, input logic [10:0] nx);
      logic [170:0] d;
      d = '0;
      d[170:160] = nx;
      d[159:149] = rid;
      d[103:0]   = m ? tup_a : ~tup_a;
      return d;
   endfunction

   task automatic write_entry(input logic [10:0] a, input logic m, input logic [10:0] rid, input logic [10:0] nx);
      int n;
      sm[a] = m; sr[a] = rid; sn[a] = nx;
      upd_addr = a; upd_data = mk_entry(m, rid, nx); upd_valid = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!upd_ready && n < 20);
      upd_valid = 1'b0;
      if (!upd_ready) chk("load_timeout", 128'd0, 128'd1);
   endtask

   // returns at 1 time unit after the accepting edge
   task automatic issue_req(input logic [10:0] head, output logic acc);
      int n;
      req_head = head; req_tuple = tup_a; req_valid = 1'b1; n = 0; acc = 1'b0;
      while (!acc && n < 50) begin
         @(negedge clk); acc = req_ready && !upd_valid;
         @(posedge clk); n++;
      end
      #1 req_valid = 1'b0;
      chk("req_accept", {127'd0, acc}, 128'd1);
   endtask

   task automatic run_lookup(input logic [10:0] head, input int stall, input logic eh,
                             input logic [10:0] er, input logic eo, input int el, input string tag);
      logic acc, we_bad, stable;
      logic [12:0] snap;
      int lat;
      issue_req(head, acc);
      chk({tag, "_tuple"}, {24'd0, tbl_tuple}, {24'd0, tup_a});
      if (head != 11'd0) chk({tag, "_idx0"}, {117'd0, tbl_search_index}, {117'd0, head});
      lat = 1; we_bad = 1'b0;
      while (!rsp_valid && lat < 100) begin
         if (tbl_we) we_bad = 1'b1;
         @(posedge clk); #1; lat++;
      end
      chk({tag, "_lat"}, 128'(lat), 128'(el));
      chk({tag, "_we_quiet"}, {127'd0, we_bad}, 128'd0);
      chk({tag, "_hit"}, {127'd0, rsp_hit}, {127'd0, eh});
      chk({tag, "_rule"}, {117'd0, rsp_ruleID}, {117'd0, er});
      chk({tag, "_ovf"}, {127'd0, rsp_overflow}, {127'd0, eo});
      snap = {rsp_hit, rsp_overflow, rsp_ruleID};
      stable = 1'b1;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk); #1;
         if (!rsp_valid || tbl_we || snap != {rsp_hit, rsp_overflow, rsp_ruleID}) stable = 1'b0;
      end
      if (stall > 0) chk({tag, "_stable"}, {127'd0, stable}, 128'd1);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({tag, "_drop"}, {127'd0, rsp_valid}, 128'd0);
   endtask

   initial begin
      logic acc, seen, eh, eo;
      logic [10:0] er, head;
      int el, n;

      rst_n = 1'b0; req_valid = 1'b0; req_tuple = '0; req_head = '0;
      upd_valid = 1'b0; upd_addr = '0; upd_data = '0; rsp_ready = 1'b0;
      tup_a[31:0] = $urandom(); tup_a[63:32] = $urandom();
      tup_a[95:64] = $urandom(); tup_a[103:96] = 8'($urandom());
      #12;
      chk_reset("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // directed chains
      write_entry(11'd5, 1, 11'd42, 11'd0);
      write_entry(11'd3, 0, 11'd0, 11'd7);
      write_entry(11'd7, 1, 11'd30, 11'd9);
      write_entry(11'd9, 1, 11'd12, 11'd0);
      write_entry(11'd10, 1, 11'd12, 11'd11);
      write_entry(11'd11, 1, 11'd50, 11'd0);
      write_entry(11'd2, 0, 11'd0, 11'd4);
      write_entry(11'd4, 0, 11'd0, 11'd0);
      write_entry(11'd1, 0, 11'd0, 11'd15);
      write_entry(11'd15, 1, 11'd99, 11'd1);

      vt[0] = '{head: 11'd5,  hit: 1'b1, rid: 11'd42, ovf: 1'b0, lat: 3,  stall: 0};
      vt[1] = '{head: 11'd3,  hit: 1'b1, rid: 11'd12, ovf: 1'b0, lat: 7,  stall: 2};
      vt[2] = '{head: 11'd10, hit: 1'b1, rid: 11'd12, ovf: 1'b0, lat: 5,  stall: 0};
      vt[3] = '{head: 11'd2,  hit: 1'b0, rid: 11'd0,  ovf: 1'b0, lat: 5,  stall: 1};
      vt[4] = '{head: 11'd0,  hit: 1'b0, rid: 11'd0,  ovf: 1'b0, lat: 1,  stall: 0};
      vt[5] = '{head: 11'd1,  hit: 1'b1, rid: 11'd99, ovf: 1'b1, lat: 39, stall: 4};
      for (int i = 0; i < 6; i++)
         run_lookup(vt[i].head, vt[i].stall, vt[i].hit, vt[i].rid, vt[i].ovf, vt[i].lat,
                    $sformatf("vec%0d", i));

      // update and lookup together: the write wins for one cycle
      sm[11'h55] = 1'b1; sr[11'h55] = 11'd77; sn[11'h55] = 11'd0;
      upd_addr = 11'h55; upd_data = mk_entry(1'b1, 11'd77, 11'd0); upd_valid = 1'b1;
      req_head = 11'h55; req_tuple = tup_a; req_valid = 1'b1;
      @(posedge clk); #1;
      chk("prio_we", {127'd0, tbl_we}, 128'd1);
      chk("prio_upd_ready", {127'd0, upd_ready}, 128'd1);
      chk("prio_req_ready", {127'd0, req_ready}, 128'd0);
      chk("prio_addr", {117'd0, tbl_search_index}, 128'h55);
      chk("prio_din", {85'd0, tbl_din[170:128]}, {85'd0, upd_data[170:128]});
      upd_valid = 1'b0;
      @(posedge clk); #1;
      chk("prio_we_once", {127'd0, tbl_we}, 128'd0);
      run_lookup(11'h55, 0, 1'b1, 11'd77, 1'b0, 3, "prio_lk");

      // update raised mid-walk is held until the walk is back in IDLE
      lk_done = 1'b0;
      fork
         begin
            run_lookup(11'd3, 3, 1'b1, 11'd12, 1'b0, 7, "walk_upd");
            lk_done = 1'b1;
         end
         begin
            repeat (3) @(posedge clk);
            #2;
            sm[11'h60] = 1'b1; sr[11'h60] = 11'd88; sn[11'h60] = 11'd0;
            upd_addr = 11'h60; upd_data = mk_entry(1'b1, 11'd88, 11'd0); upd_valid = 1'b1;
            seen = 1'b0; n = 0;
            while (!seen && n < 100) begin @(negedge clk); seen = upd_ready; n++; end
            chk("upd_after_walk", {127'd0, lk_done}, 128'd1);
            chk("upd_held_we", {127'd0, tbl_we}, 128'd1);
            @(posedge clk); #1 upd_valid = 1'b0;
         end
      join
      run_lookup(11'h60, 0, 1'b1, 11'd88, 1'b0, 3, "upd_lk");

      // reset during EVAL of a two-hop walk drops the request
      issue_req(11'd10, acc);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset("midrst");
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      chk("midrst_no_rsp", {127'd0, seen}, 128'd0);
      @(posedge clk); #1;
      run_lookup(11'd10, 0, 1'b1, 11'd12, 1'b0, 5, "post_rst");

      // random chains in 100..163 (may loop), checked against the reference walk
      for (int a = 100; a < 164; a++)
         write_entry(11'(a), 1'($urandom_range(0, 1)), 11'($urandom_range(1, 2046)),
                     ($urandom_range(0, 3) == 0) ? 11'd0 : 11'(100 + $urandom_range(0, 63)));
      for (int i = 0; i < 16; i++) begin
         head = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'(100 + $urandom_range(0, 63));
         ref_walk(head, eh, er, eo, el);
         run_lookup(head, $urandom_range(0, 2), eh, er, eo, el, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
